// File: rtl/line_pkg.sv
// Shared definitions for the line rasteriser.
//   state_t    : engine FSM states
//   X_W / Y_W  : default coordinate widths
//   H_RES/V_RES: default visible area; coordinates at or beyond these are off-screen
//   ERR_W/E2_W : Bresenham error-term widths for the default coordinate widths
package line_pkg;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  // err spans [-(2^Y_W-1), 2^X_W-1]; two guard bits keep it sign-safe.
  function automatic int unsigned err_width(input int unsigned xw, input int unsigned yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int unsigned ERR_W = err_width(X_W, Y_W);
  localparam int unsigned E2_W  = ERR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/line_engine.sv
// Line rasteriser, responder side of the line-request handshake.
// Accepts (x0,y0)->(x1,y1) plus colour when req_valid && req_ready, then emits
// one Bresenham pixel per cycle on x/y/pixel_color/pixel_write and pulses done.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   x0,y0,x1,y1,color   : line endpoints and colour, captured on accept
//   abort               : cancels the line in SETUP or DRAW, no done
//   x,y,pixel_color     : current pixel
//   pixel_write         : write strobe, suppressed for off-screen points
//   busy                : high in SETUP or DRAW
//   done                : one-cycle pulse when the line completes
module line_engine #(
  parameter int unsigned X_W   = line_pkg::X_W,
  parameter int unsigned Y_W   = line_pkg::Y_W,
  parameter int unsigned H_RES = line_pkg::H_RES,
  parameter int unsigned V_RES = line_pkg::V_RES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic           color,
  input  logic           abort,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pixel_color,
  output logic           pixel_write,
  output logic           busy,
  output logic           done
);
  import line_pkg::*;

  localparam int unsigned EW  = err_width(X_W, Y_W);
  localparam int unsigned E2W = EW + 1;
  localparam int unsigned DYW = Y_W + 2;

  localparam logic [X_W:0] H_LIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W + 1)'(V_RES);

  state_t state_q, state_d;

  logic [X_W-1:0]        cx, x_end, dx;
  logic [Y_W-1:0]        cy, y_end;
  logic                  col, sx_neg, sy_neg;
  logic signed [DYW-1:0] dy;
  logic signed [EW-1:0]  err;

  // Setup-phase arithmetic; cx/cy hold x0/y0 while in SETUP.
  logic signed [X_W:0]   xdiff;
  logic signed [Y_W:0]   ydiff;
  logic [X_W-1:0]        dx_s;
  logic [Y_W-1:0]        ady_s;
  logic signed [DYW-1:0] dy_s;
  logic signed [EW-1:0]  err_s;

  always_comb begin
    xdiff = $signed({1'b0, x_end}) - $signed({1'b0, cx});
    ydiff = $signed({1'b0, y_end}) - $signed({1'b0, cy});
    dx_s  = xdiff[X_W] ? X_W'(-xdiff) : xdiff[X_W-1:0];
    ady_s = ydiff[Y_W] ? Y_W'(-ydiff) : ydiff[Y_W-1:0];
    dy_s  = -$signed({2'b00, ady_s});
    err_s = $signed(EW'(dx_s)) + EW'(dy_s);
  end

  // Draw-phase step; both error updates are taken from the old err.
  logic signed [E2W-1:0] e2;
  logic                  step_x, step_y, at_end;
  logic signed [EW-1:0]  add_x, add_y, err_n;

  always_comb begin
    e2     = $signed({err, 1'b0});
    step_x = (e2 >= E2W'(dy));
    step_y = (e2 <= $signed(E2W'({1'b0, dx})));
    add_x  = step_x ? EW'(dy) : '0;
    add_y  = step_y ? $signed(EW'(dx)) : '0;
    err_n  = err + add_x + add_y;
    at_end = (cx == x_end) && (cy == y_end);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = abort ? IDLE : DRAW;
      DRAW:    if (abort) state_d = IDLE;
               else if (at_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx     <= '0;
      cy     <= '0;
      x_end  <= '0;
      y_end  <= '0;
      col    <= 1'b0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          cx    <= x0;
          cy    <= y0;
          x_end <= x1;
          y_end <= y1;
          col   <= color;
        end
        SETUP: begin
          dx     <= dx_s;
          dy     <= dy_s;
          sx_neg <= (x_end < cx);
          sy_neg <= (y_end < cy);
          err    <= err_s;
        end
        DRAW: if (!abort && !at_end) begin
          err <= err_n;
          if (step_x) cx <= sx_neg ? cx - 1'b1 : cx + 1'b1;
          if (step_y) cy <= sy_neg ? cy - 1'b1 : cy + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    busy        = (state_q == SETUP) || (state_q == DRAW);
    done        = (state_q == DONE);
    x           = cx;
    y           = cy;
    pixel_color = col;
    pixel_write = (state_q == DRAW) && ({1'b0, cx} < H_LIM) && ({1'b0, cy} < V_LIM);
  end

endmodule
